// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
//
// Shares one single-port data RAM between the core controller (LOAD/STORE)
// and the IO loader (LD_RAM/OUT_RAM).
//
// Each requester uses a valid/ready style handshake. A transfer happens when
// req and gnt are both high at a rising clock edge. The winning request is
// captured into a registered RAM command stage. Read data is steered back to
// the requester that issued the read, using a two-stage owner tag.
//
// Arbitration:
//   - The core has fixed priority.
//   - The IO port wins instead while interrupt is high.
//   - The IO port also wins once it has been refused MAX_WAIT cycles in a row.
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   interrupt            IO-priority mode
//   core_req/we/addr/wdata   core request (inputs)
//   core_gnt             core accepted this cycle (combinational)
//   core_rvalid/rdata    core read return, one cycle wide
//   io_req/we/addr/wdata     IO request (inputs)
//   io_gnt               IO accepted this cycle (combinational)
//   io_rvalid/rdata      IO read return, one cycle wide
//   ram_en/we/addr/wdata registered RAM command
//   ram_rdata            RAM read data, valid the cycle after a read command
//   owner                last stage-1 owner (0 idle, 1 core, 2 io), for
//                        observation only
// -----------------------------------------------------------------------------
module ram_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              interrupt,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] io_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        owner
);

  // Wide enough to hold the value MAX_WAIT itself.
  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  // Owner encoding of the informational grant FSM.
  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_CORE = 2'd1;
  localparam logic [1:0] OWN_IO   = 2'd2;

  logic [WAIT_W-1:0] r_io_wait;
  logic              w_starve;
  logic              w_core_gnt;
  logic              w_io_gnt;

  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;

  // Tag bit [1] marks a core read and bit [0] marks an IO read.
  // rd_tag travels with the RAM command; rv_tag lines up with ram_rdata.
  logic [1:0]        r_rd_tag;
  logic [1:0]        r_rv_tag;

  logic [1:0]        r_owner;
  logic [1:0]        w_owner_nxt;

  // Grant decode.
  // The IO port overrides the core when interrupt is high or when it is
  // starved. Grants are held low for the whole reset cycle, so nothing
  // is accepted while reset is high.
  always_comb begin
    w_starve   = (r_io_wait == WAIT_SAT);
    w_core_gnt = core_req & ~reset & ~(io_req & (interrupt | w_starve));
    w_io_gnt   = io_req & ~reset & ~w_core_gnt;
  end

  assign core_gnt = w_core_gnt;
  assign io_gnt   = w_io_gnt;

  // IO starvation counter.
  // It counts refused IO request cycles and saturates at MAX_WAIT.
  // It is independent of interrupt.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_io_wait <= {WAIT_W{1'b0}};
    end else if (w_io_gnt || !io_req) begin
      r_io_wait <= {WAIT_W{1'b0}};
    end else if (r_io_wait != WAIT_SAT) begin
      r_io_wait <= r_io_wait + WAIT_ONE;
    end else begin
      r_io_wait <= r_io_wait;
    end
  end

  // Stage-1 RAM command register.
  // When no transfer happens, the address and write data hold their values.
  // This keeps the RAM inputs quiet between accesses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= {ADDR_W{1'b0}};
      r_ram_wdata <= {DATA_W{1'b0}};
    end else if (w_core_gnt) begin
      r_ram_en    <= 1'b1;
      r_ram_we    <= core_we;
      r_ram_addr  <= core_addr;
      r_ram_wdata <= core_wdata;
    end else if (w_io_gnt) begin
      r_ram_en    <= 1'b1;
      r_ram_we    <= io_we;
      r_ram_addr  <= io_addr;
      r_ram_wdata <= io_wdata;
    end else begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= r_ram_addr;
      r_ram_wdata <= r_ram_wdata;
    end
  end

  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;

  // Read owner tag pipeline.
  // Reset clears both stages. Any read still in flight therefore never
  // produces an rvalid after the reset edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_tag <= 2'b00;
      r_rv_tag <= 2'b00;
    end else begin
      r_rd_tag <= {w_core_gnt & ~core_we, w_io_gnt & ~io_we};
      r_rv_tag <= r_rd_tag;
    end
  end

  // Read return steering.
  // The data bus is forced to zero outside the valid cycle. This stops
  // stale RAM output from leaking to the requester that did not own it.
  always_comb begin
    core_rvalid = r_rv_tag[1];
    io_rvalid   = r_rv_tag[0];
    if (r_rv_tag[1]) begin
      core_rdata = ram_rdata;
    end else begin
      core_rdata = {DATA_W{1'b0}};
    end
    if (r_rv_tag[0]) begin
      io_rdata = ram_rdata;
    end else begin
      io_rdata = {DATA_W{1'b0}};
    end
  end

  // Next owner of the informational grant FSM.
  // The owner follows whoever loaded stage 1 and holds through idle cycles.
  always_comb begin
    w_owner_nxt = r_owner;
    case (r_owner)
      OWN_IDLE, OWN_CORE, OWN_IO: begin
        if (w_core_gnt) begin
          w_owner_nxt = OWN_CORE;
        end else if (w_io_gnt) begin
          w_owner_nxt = OWN_IO;
        end else begin
          w_owner_nxt = r_owner;
        end
      end
      default: begin
        w_owner_nxt = OWN_IDLE;
      end
    endcase
  end

  // Owner state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner <= OWN_IDLE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  assign owner = r_owner;

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
//
// Self-checking bench for ram_arbiter.
//
// A behavioural RAM with one-cycle read latency sits on the ram_* port.
// A shadow copy of the RAM is updated at every accepted write. Each accepted
// read pushes its expected data and due cycle (transfer cycle + 2) onto a
// per-requester queue. A negedge monitor pops those queues and compares them
// with the rvalid/rdata outputs.
//
// Scenario tasks check grants and RAM command timing inline.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;

  logic       clk;
  logic       reset;
  logic       interrupt;
  logic       core_req, core_we;
  logic [7:0] core_addr, core_wdata;
  logic       core_gnt, core_rvalid;
  logic [7:0] core_rdata;
  logic       io_req, io_we;
  logic [7:0] io_addr, io_wdata;
  logic       io_gnt, io_rvalid;
  logic [7:0] io_rdata;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata;
  logic [7:0] ram_rdata;
  logic [1:0] owner;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    int         due;
    logic [7:0] data;
  } sb_t;

  sb_t        core_q[$];
  sb_t        io_q[$];
  logic [7:0] mem   [256];
  logic [7:0] shadow[256];
  logic       exp_cv, exp_iv;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(4)) dut (
    .clock      (clk),
    .reset      (reset),
    .interrupt  (interrupt),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_gnt   (core_gnt),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .io_req     (io_req),
    .io_we      (io_we),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_gnt     (io_gnt),
    .io_rvalid  (io_rvalid),
    .io_rdata   (io_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .owner      (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // Scoreboard monitor: checks read returns and records new transfers.
  always @(negedge clk) begin
    if (reset) begin
      core_q.delete();
      io_q.delete();
    end else begin
      while (core_q.size() > 0 && core_q[0].due < cyc) void'(core_q.pop_front());
      while (io_q.size() > 0 && io_q[0].due < cyc) void'(io_q.pop_front());

      exp_cv = (core_q.size() > 0) && (core_q[0].due == cyc);
      n_checks++;
      if (core_rvalid !== exp_cv)
        $display("FAIL sb_core_rvalid cyc=%0d: got %0b want %0b", cyc, core_rvalid, exp_cv);
      else n_pass++;
      if (exp_cv) begin
        n_checks++;
        if (core_rdata !== core_q[0].data)
          $display("FAIL sb_core_rdata cyc=%0d: got %02h want %02h", cyc, core_rdata, core_q[0].data);
        else n_pass++;
        void'(core_q.pop_front());
      end else begin
        n_checks++;
        if (core_rdata !== 8'h00)
          $display("FAIL sb_core_rdata_idle cyc=%0d: got %02h want 00", cyc, core_rdata);
        else n_pass++;
      end

      exp_iv = (io_q.size() > 0) && (io_q[0].due == cyc);
      n_checks++;
      if (io_rvalid !== exp_iv)
        $display("FAIL sb_io_rvalid cyc=%0d: got %0b want %0b", cyc, io_rvalid, exp_iv);
      else n_pass++;
      if (exp_iv) begin
        n_checks++;
        if (io_rdata !== io_q[0].data)
          $display("FAIL sb_io_rdata cyc=%0d: got %02h want %02h", cyc, io_rdata, io_q[0].data);
        else n_pass++;
        void'(io_q.pop_front());
      end else begin
        n_checks++;
        if (io_rdata !== 8'h00)
          $display("FAIL sb_io_rdata_idle cyc=%0d: got %02h want 00", cyc, io_rdata);
        else n_pass++;
      end

      n_checks++;
      if (core_gnt && io_gnt)
        $display("FAIL sb_one_gnt cyc=%0d: got both grants want at most one", cyc);
      else n_pass++;

      if (core_req && core_gnt) begin
        if (core_we) shadow[core_addr] = core_wdata;
        else core_q.push_back('{due: cyc + 2, data: shadow[core_addr]});
      end
      if (io_req && io_gnt) begin
        if (io_we) shadow[io_addr] = io_wdata;
        else io_q.push_back('{due: cyc + 2, data: shadow[io_addr]});
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    core_req = 1'b0;
    io_req = 1'b0;
    interrupt = 1'b0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    core_req = 1'b1;
    io_req = 1'b1;
    core_we = 1'b0;
    io_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (core_gnt !== 1'b0) $display("FAIL reset_core_gnt: got %0b want 0", core_gnt); else n_pass++;
      n_checks++;
      if (io_gnt !== 1'b0) $display("FAIL reset_io_gnt: got %0b want 0", io_gnt); else n_pass++;
      if (i == 1) begin
        n_checks++;
        if (ram_en !== 1'b0) $display("FAIL reset_ram_en: got %0b want 0", ram_en); else n_pass++;
        n_checks++;
        if ({core_rvalid, io_rvalid} !== 2'b00) $display("FAIL reset_rvalid: got %02b want 00", {core_rvalid, io_rvalid}); else n_pass++;
        n_checks++;
        if (dut.r_io_wait !== 3'd0) $display("FAIL reset_io_wait: got %0d want 0", dut.r_io_wait); else n_pass++;
        n_checks++;
        if (owner !== 2'd0) $display("FAIL reset_owner: got %0d want 0", owner); else n_pass++;
      end
      next_cycle();
    end
    reset = 1'b0;
    drain(2);
  endtask

  task automatic test_core_read();
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h12;
    @(negedge clk);
    n_checks++;
    if ({core_gnt, io_gnt} !== 2'b10) $display("FAIL cr_gnt: got %02b want 10", {core_gnt, io_gnt}); else n_pass++;
    next_cycle();
    core_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 8'h12})
      $display("FAIL cr_ram_cmd: got en=%0b we=%0b a=%02h want en=1 we=0 a=12", ram_en, ram_we, ram_addr);
    else n_pass++;
    n_checks++;
    if (core_rvalid !== 1'b0) $display("FAIL cr_rvalid_c1: got %0b want 0", core_rvalid); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({core_rvalid, core_rdata} !== {1'b1, 8'hA5})
      $display("FAIL cr_rdata_c2: got v=%0b d=%02h want v=1 d=a5", core_rvalid, core_rdata);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (core_rvalid !== 1'b0) $display("FAIL cr_rvalid_c3: got %0b want 0", core_rvalid); else n_pass++;
    n_checks++;
    if (owner !== 2'd1) $display("FAIL cr_owner: got %0d want 1", owner); else n_pass++;
    drain(1);
  endtask

  task automatic test_write_then_read();
    core_req = 1'b1; core_we = 1'b1; core_addr = 8'h34; core_wdata = 8'h5A;
    io_req = 1'b1; io_we = 1'b0; io_addr = 8'h34;
    @(negedge clk);
    n_checks++;
    if ({core_gnt, io_gnt} !== 2'b10) $display("FAIL wr_c0_gnt: got %02b want 10", {core_gnt, io_gnt}); else n_pass++;
    next_cycle();
    core_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (io_gnt !== 1'b1) $display("FAIL wr_c1_io_gnt: got %0b want 1", io_gnt); else n_pass++;
    n_checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 8'h34, 8'h5A})
      $display("FAIL wr_c1_ram_cmd: got en=%0b we=%0b a=%02h d=%02h want 1 1 34 5a", ram_en, ram_we, ram_addr, ram_wdata);
    else n_pass++;
    next_cycle();
    io_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 8'h34})
      $display("FAIL wr_c2_ram_cmd: got en=%0b we=%0b a=%02h want 1 0 34", ram_en, ram_we, ram_addr);
    else n_pass++;
    n_checks++;
    if (owner !== 2'd2) $display("FAIL wr_c2_owner: got %0d want 2", owner); else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({io_rvalid, io_rdata, core_rvalid} !== {1'b1, 8'h5A, 1'b0})
      $display("FAIL wr_c3_ret: got iov=%0b iod=%02h cv=%0b want 1 5a 0", io_rvalid, io_rdata, core_rvalid);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({io_rvalid, ram_en} !== 2'b00) $display("FAIL wr_c4_idle: got %02b want 00", {io_rvalid, ram_en}); else n_pass++;
    n_checks++;
    if (owner !== 2'd2) $display("FAIL wr_c4_owner_hold: got %0d want 2", owner); else n_pass++;
    drain(1);
  endtask

  task automatic test_starvation();
    logic exp_c;
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h20;
    io_req = 1'b1; io_we = 1'b0; io_addr = 8'h40;
    for (int c = 0; c < 6; c++) begin
      exp_c = (c != 4);
      @(negedge clk);
      n_checks++;
      if ({core_gnt, io_gnt} !== {exp_c, ~exp_c})
        $display("FAIL starve_gnt_c%0d: got %02b want %02b", c, {core_gnt, io_gnt}, {exp_c, ~exp_c});
      else n_pass++;
      if (c == 4) begin
        n_checks++;
        if (dut.r_io_wait !== 3'd4) $display("FAIL starve_wait_sat: got %0d want 4", dut.r_io_wait); else n_pass++;
      end
      if (c == 5) begin
        n_checks++;
        if (dut.r_io_wait !== 3'd0) $display("FAIL starve_wait_clr: got %0d want 0", dut.r_io_wait); else n_pass++;
      end
      next_cycle();
      core_addr = core_addr + 8'd1;
    end
    core_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (io_gnt !== 1'b1) $display("FAIL starve_io_retry: got %0b want 1", io_gnt); else n_pass++;
    next_cycle();
    drain(3);
  endtask

  task automatic test_interrupt();
    interrupt = 1'b1;
    core_req = 1'b1; core_we = 1'b1; core_addr = 8'h50; core_wdata = 8'h77;
    io_req = 1'b1; io_we = 1'b0; io_addr = 8'h51;
    @(negedge clk);
    n_checks++;
    if ({core_gnt, io_gnt} !== 2'b01) $display("FAIL irq_io_wins: got %02b want 01", {core_gnt, io_gnt}); else n_pass++;
    next_cycle();
    interrupt = 1'b0; io_addr = 8'h52;
    @(negedge clk);
    n_checks++;
    if ({core_gnt, io_gnt} !== 2'b10) $display("FAIL irq_off_core_wins: got %02b want 10", {core_gnt, io_gnt}); else n_pass++;
    next_cycle();
    core_req = 1'b0; interrupt = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({core_gnt, io_gnt} !== 2'b01) $display("FAIL irq_io_only: got %02b want 01", {core_gnt, io_gnt}); else n_pass++;
    next_cycle();
    io_req = 1'b0; core_req = 1'b1; core_we = 1'b0; core_addr = 8'h50;
    @(negedge clk);
    n_checks++;
    if ({core_gnt, io_gnt} !== 2'b10) $display("FAIL irq_core_alone: got %02b want 10", {core_gnt, io_gnt}); else n_pass++;
    next_cycle();
    drain(3);
  endtask

  task automatic test_reset_mid_access();
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h60;
    @(negedge clk);
    n_checks++;
    if (core_gnt !== 1'b1) $display("FAIL rm_gnt: got %0b want 1", core_gnt); else n_pass++;
    next_cycle();
    core_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ram_en, ram_addr} !== {1'b1, 8'h60}) $display("FAIL rm_c1_cmd: got en=%0b a=%02h want 1 60", ram_en, ram_addr); else n_pass++;
    next_cycle();
    reset = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      if (c == 2) begin
        n_checks++;
        if (ram_en !== 1'b0) $display("FAIL rm_c2_ram_en: got %0b want 0", ram_en); else n_pass++;
      end
      n_checks++;
      if (core_rvalid !== 1'b0) $display("FAIL rm_rvalid_c%0d: got %0b want 0", c, core_rvalid); else n_pass++;
      next_cycle();
    end
    drain(1);
  endtask

  task automatic test_back_to_back();
    int   m_wait = 0;
    logic core_took = 1'b0;
    logic io_took = 1'b0;
    logic exp_c, exp_i;
    for (int n = 0; n < 400; n++) begin
      if (!core_req || core_took) begin
        core_req = ($urandom_range(3) != 0);
        core_we = $urandom_range(1);
        core_addr = 8'($urandom_range(7));
        core_wdata = 8'($urandom_range(255));
      end
      if (!io_req || io_took) begin
        io_req = ($urandom_range(3) != 0);
        io_we = $urandom_range(1);
        io_addr = 8'($urandom_range(7));
        io_wdata = 8'($urandom_range(255));
      end
      interrupt = ($urandom_range(7) == 0);
      @(negedge clk);
      exp_c = core_req & ~(io_req & (interrupt | (m_wait == 4)));
      exp_i = io_req & ~exp_c;
      n_checks++;
      if ({core_gnt, io_gnt} !== {exp_c, exp_i})
        $display("FAIL b2b_gnt n=%0d: got %02b want %02b", n, {core_gnt, io_gnt}, {exp_c, exp_i});
      else n_pass++;
      if (exp_i || !io_req) m_wait = 0;
      else if (m_wait < 4) m_wait = m_wait + 1;
      core_took = core_req & core_gnt;
      io_took = io_req & io_gnt;
      next_cycle();
    end
    drain(4);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'hB7;
      shadow[i] = 8'(i) ^ 8'hB7;
    end
    reset = 1'b1;
    interrupt = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = 8'h00; core_wdata = 8'h00;
    io_req = 1'b0; io_we = 1'b0; io_addr = 8'h00; io_wdata = 8'h00;
    next_cycle();
    test_reset();
    test_core_read();
    test_write_then_read();
    test_starvation();
    test_interrupt();
    test_reset_mid_access();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
